// File: rtl/stream_avg_pkg.sv
// Shared constants and FSM encoding for the stream moving-average stage.
//   DEF_WIDTH / DEF_FIFO_DEPTH / DEF_WIN_LOG2 : default parameter values
//   SUM_W   : running-sum width for the default configuration
//   state_t : FSM state type with IDLE / CALC / OUT encodings
package stream_avg_pkg;

  localparam int unsigned DEF_WIDTH      = 32;
  localparam int unsigned DEF_FIFO_DEPTH = 4;
  localparam int unsigned DEF_WIN_LOG2   = 2;

  // WIN_LOG2 guard bits: sum of 2^WIN_LOG2 WIDTH-bit samples can never overflow.
  localparam int unsigned SUM_W = DEF_WIDTH + DEF_WIN_LOG2;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t OUT  = 2'd2;

endpackage

// File: rtl/stream_moving_avg_if.sv
// Sample / result stream bundle between the Wishbone bridge and the averager.
//   i_stream_val/rdy/data : samples into the averager
//   o_stream_val/rdy/data : results back to the bridge
// master = bridge side, slave = averager side.
interface stream_moving_avg_if #(
  parameter int unsigned WIDTH = 32
);

  logic             i_stream_val;
  logic             i_stream_rdy;
  logic [WIDTH-1:0] i_stream_data;
  logic             o_stream_val;
  logic             o_stream_rdy;
  logic [WIDTH-1:0] o_stream_data;

  modport master (
    output i_stream_val,
    input  i_stream_rdy,
    output i_stream_data,
    input  o_stream_val,
    output o_stream_rdy,
    input  o_stream_data
  );

  modport slave (
    input  i_stream_val,
    output i_stream_rdy,
    input  i_stream_data,
    output o_stream_val,
    input  o_stream_rdy,
    output o_stream_data
  );

endinterface

// File: rtl/stream_sync_fifo.sv
// Parameterised synchronous FIFO (power-of-two depth, >= 2).
//   clk, reset : clock, synchronous active-high reset
//   push/wdata : write request and data (ignored while full)
//   pop/rdata  : read request (ignored while empty); rdata shows the head
//   full/empty : status flags decoded from count
//   count      : registered occupancy, 0..DEPTH
module stream_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_moving_avg.sv
// Moving-average stage behind the Wishbone bridge. Each accepted signed sample
// goes through a small FIFO, is folded into a 2^WIN_LOG2-sample window, and one
// average (window sum >>> WIN_LOG2) is returned per sample, in input order.
//   clk, reset : clock, synchronous active-high reset
//   bus        : stream_moving_avg_if.slave (sample in, result out)
//   o_drop     : sticky "sample offered while not ready" flag, present only
//                when STREAM_AVG_DROP_FLAG_EN is defined
module stream_moving_avg
  import stream_avg_pkg::*;
#(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2
) (
  input  logic clk,
  input  logic reset,
`ifdef STREAM_AVG_DROP_FLAG_EN
  output logic o_drop,
`endif
  stream_moving_avg_if.slave bus
);

  localparam int unsigned N     = 1 << WIN_LOG2;
  localparam int unsigned ACC_W = WIDTH + WIN_LOG2;
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;

  state_t                  state_q, state_d;
  logic signed [WIDTH-1:0] sample_q;
  logic signed [WIDTH-1:0] data_q;
  logic signed [WIDTH-1:0] win_q [N];
  logic signed [ACC_W-1:0] sum_q, sum_next, old_ext, new_ext;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_empty;
  logic [WIDTH-1:0]        fifo_rdata;
  logic                    push, pop;

  // Ready comes from the registered count only, so a full FIFO refuses a push
  // even when the FSM pops in the same cycle.
  assign bus.i_stream_rdy = (fifo_count != CW'(FIFO_DEPTH));
  assign push             = bus.i_stream_val && bus.i_stream_rdy;
  assign pop              = (state_q == IDLE) && !fifo_empty;

  stream_sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.i_stream_data),
    .rdata (fifo_rdata),
    .full  (),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Size casts of signed operands sign-extend into the guard bits.
  assign old_ext  = ACC_W'(win_q[N-1]);
  assign new_ext  = ACC_W'(sample_q);
  assign sum_next = sum_q - old_ext + new_ext;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (!fifo_empty) state_d = CALC;
      CALC:    state_d = OUT;
      OUT:     if (bus.o_stream_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sample_q <= '0;
      data_q   <= '0;
      sum_q    <= '0;
      for (int k = 0; k < int'(N); k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      if (pop) sample_q <= fifo_rdata;
      if (state_q == CALC) begin
        sum_q    <= sum_next;
        win_q[0] <= sample_q;
        for (int k = 1; k < int'(N); k++) win_q[k] <= win_q[k-1];
        data_q   <= WIDTH'(sum_next >>> WIN_LOG2);
      end
    end
  end

  assign bus.o_stream_val  = (state_q == OUT);
  assign bus.o_stream_data = data_q;

`ifdef STREAM_AVG_DROP_FLAG_EN
  logic drop_q;

  always_ff @(posedge clk) begin
    if (reset) drop_q <= 1'b0;
    else if (bus.i_stream_val && !bus.i_stream_rdy) drop_q <= 1'b1;
  end

  assign o_drop = drop_q;
`endif

endmodule

// File: tb/tb_stream_moving_avg.sv
// Directed bench for stream_moving_avg: a vector table for single-sample
// transactions plus hand-written sequences for back-pressure, FIFO fill,
// mid-operation reset and producer pulses that ignore ready.
module tb_stream_moving_avg;

  logic clk = 1'b0;
  logic reset;
`ifdef STREAM_AVG_DROP_FLAG_EN
  logic drop;
`endif

  int total = 0;
  int bad   = 0;

  stream_moving_avg_if #(.WIDTH(32)) sbus ();

  stream_moving_avg #(
    .WIDTH      (32),
    .FIFO_DEPTH (4),
    .WIN_LOG2   (2)
  ) dut (
    .clk    (clk),
    .reset  (reset),
`ifdef STREAM_AVG_DROP_FLAG_EN
    .o_drop (drop),
`endif
    .bus    (sbus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          rst;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] d);
    sbus.i_stream_val  = 1'b1;
    sbus.i_stream_data = d;
    tick();
    sbus.i_stream_val  = 1'b0;
  endtask

  // Advance until o_stream_val is seen or the budget runs out.
  task automatic wait_val(input int budget, output bit got, output int waited);
    got    = 1'b0;
    waited = 0;
    for (int i = 0; i < budget; i++) begin
      if (sbus.o_stream_val) begin
        got = 1'b1;
        break;
      end
      tick();
      waited++;
    end
  endtask

  initial begin
    bit          got;
    int          waited;
    bit          ok;
    bit          rdy_seen [6];
    int          accepted;
    logic [31:0] bp_exp [5];

    // 4,8,12,16 -> partial averages 1,3,6,10; then four -8 -> -2,-4,-6,-8.
    vecs[0] = '{1'b1, 32'd4,         32'd1};
    vecs[1] = '{1'b0, 32'd8,         32'd3};
    vecs[2] = '{1'b0, 32'd12,        32'd6};
    vecs[3] = '{1'b0, 32'd16,        32'd10};
    vecs[4] = '{1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFE};
    vecs[5] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFC};
    vecs[6] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFA};
    vecs[7] = '{1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFF8};

    sbus.i_stream_val  = 1'b0;
    sbus.i_stream_data = '0;
    sbus.o_stream_rdy  = 1'b1;
    reset              = 1'b1;
    tick();
    tick();
    check("rst_i_rdy", 32'(sbus.i_stream_rdy), 32'd1);
    check("rst_o_val", 32'(sbus.o_stream_val), 32'd0);
    check("rst_o_data", sbus.o_stream_data, 32'd0);
`ifdef STREAM_AVG_DROP_FLAG_EN
    check("rst_drop", 32'(drop), 32'd0);
`endif
    reset = 1'b0;

    // Table: one sample in, one result out, val lasts a single cycle.
    for (int v = 0; v < 8; v++) begin
      if (vecs[v].rst) do_reset();
      push(vecs[v].din);
      wait_val(6, got, waited);
      check($sformatf("vec%0d_val", v), 32'(got), 32'd1);
      if (v == 0) check("latency_le3", 32'(waited <= 3), 32'd1);
      check($sformatf("vec%0d_data", v), sbus.o_stream_data, vecs[v].exp);
      tick();
      check($sformatf("vec%0d_pulse", v), 32'(sbus.o_stream_val), 32'd0);
    end

    // Back-pressure hold: 40 after reset -> 10, held while o_stream_rdy=0.
    do_reset();
    sbus.o_stream_rdy = 1'b0;
    push(32'd40);
    wait_val(6, got, waited);
    check("hold_val", 32'(got), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!sbus.o_stream_val || sbus.o_stream_data !== 32'd10) ok = 1'b0;
      tick();
    end
    check("hold_stable", 32'(ok), 32'd1);
    sbus.o_stream_rdy = 1'b1;
    tick();
    check("hold_release", 32'(sbus.o_stream_val), 32'd0);

    // FIFO fill: one sample reaches the FSM, four fill the FIFO, sixth refused.
    do_reset();
    sbus.o_stream_rdy = 1'b0;
    accepted = 0;
    for (int k = 0; k < 6; k++) begin
      rdy_seen[k]        = sbus.i_stream_rdy;
      if (rdy_seen[k]) accepted++;
      sbus.i_stream_val  = 1'b1;
      sbus.i_stream_data = 32'((k + 1) * 10);
      tick();
    end
    sbus.i_stream_val = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd5);
    check("fill_rdy_before_full", 32'(rdy_seen[4]), 32'd1);
    check("fill_rdy_at_full", 32'(rdy_seen[5]), 32'd0);
    check("fill_rdy_after", 32'(sbus.i_stream_rdy), 32'd0);
`ifdef STREAM_AVG_DROP_FLAG_EN
    check("fill_drop", 32'(drop), 32'd1);
`endif
    // 10,20,30,40,50 -> sums 10,30,60,100,140 -> 2,7,15,25,35; 60 must not appear.
    bp_exp[0] = 32'd2;
    bp_exp[1] = 32'd7;
    bp_exp[2] = 32'd15;
    bp_exp[3] = 32'd25;
    bp_exp[4] = 32'd35;
    sbus.o_stream_rdy = 1'b1;
    for (int r = 0; r < 5; r++) begin
      wait_val(8, got, waited);
      check($sformatf("fill_res%0d_val", r), 32'(got), 32'd1);
      check($sformatf("fill_res%0d_data", r), sbus.o_stream_data, bp_exp[r]);
      tick();
    end
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sbus.o_stream_val) ok = 1'b0;
      tick();
    end
    check("fill_no_extra", 32'(ok), 32'd1);

    // Reset while in OUT with samples queued.
    do_reset();
    sbus.o_stream_rdy = 1'b0;
    push(32'd1);
    push(32'd2);
    push(32'd3);
    push(32'd4);
    wait_val(6, got, waited);
    check("midrst_out", 32'(got), 32'd1);
    reset = 1'b1;
    tick();
    check("midrst_val", 32'(sbus.o_stream_val), 32'd0);
    check("midrst_rdy", 32'(sbus.i_stream_rdy), 32'd1);
    reset = 1'b0;
    sbus.o_stream_rdy = 1'b1;
    push(32'd100);
    wait_val(6, got, waited);
    check("midrst_res_val", 32'(got), 32'd1);
    check("midrst_res_data", sbus.o_stream_data, 32'd25);
    tick();
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sbus.o_stream_val) ok = 1'b0;
      tick();
    end
    check("midrst_flushed", 32'(ok), 32'd1);

    // Producer pulses that ignore ready: 1000 then 2000 -> 250, 750.
    do_reset();
    sbus.o_stream_rdy = 1'b1;
    push(32'd1000);
    tick();
    push(32'd2000);
    wait_val(8, got, waited);
    check("pulse0_val", 32'(got), 32'd1);
    check("pulse0_data", sbus.o_stream_data, 32'd250);
    tick();
    wait_val(8, got, waited);
    check("pulse1_val", 32'(got), 32'd1);
    check("pulse1_data", sbus.o_stream_data, 32'd750);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
